// File: rtl/dct_pkg.sv
// Shared constants and the round/saturate helper for the DCT product
// accumulator stage.
package dct_pkg;

    localparam int PROD_W = 29;
    localparam int N_TAPS = 8;
    localparam int SHIFT  = 13;
    localparam int OUT_W  = 16;
    localparam int N_OUT  = 8;
    localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
    localparam int TAP_W  = $clog2(N_TAPS);
    localparam int ROW_W  = $clog2(N_OUT);
    localparam int RND_W  = ACC_W + 1 - SHIFT;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);
    localparam logic [ACC_W:0]   RND_HALF = {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    // One extra bit of headroom keeps sum + half from wrapping at full scale.
    function automatic logic [OUT_W-1:0] sat_round(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W:0]   rnd;
        logic signed [RND_W-1:0] r;
        logic [OUT_W-1:0]        res;
        rnd = $signed({sum[ACC_W-1], sum}) + $signed(RND_HALF);
        r   = RND_W'(rnd >>> SHIFT);
        if ((r[RND_W-1:OUT_W-1] == {(RND_W - OUT_W + 1){1'b0}}) ||
            (r[RND_W-1:OUT_W-1] == {(RND_W - OUT_W + 1){1'b1}})) begin
            res = r[OUT_W-1:0];
        end else if (r[RND_W-1]) begin
            res = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W - 1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/dct_acc_out_fifo.sv
// Two-entry result FIFO; the head entry drives the stage outputs directly.
module dct_acc_out_fifo
    import dct_pkg::*;
#(
    parameter int W = OUT_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Pointer, storage and occupancy update.
    always_comb begin
        push_ok_s = push && (count_q != 2'd2);
        pop_ok_s  = pop && (count_q != 2'd0);
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = ~rd_q;
        end else begin
            rd_d = rd_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {W{1'b0}};
            mem_q[1] <= {W{1'b0}};
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/dct_mac_accum.sv
// Sums N_TAPS multiplier products per coefficient, rounds/saturates the sum
// and hands results downstream through a 2-entry buffer that back-pressures ce_out.
module dct_mac_accum
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              ce_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    accept_s;
    logic                    push_s;
    logic                    pop_s;
    logic [OUT_W:0]          push_data_s;
    logic [OUT_W:0]          head_s;
    logic [1:0]              count_s;

    assign ce_out     = (count_s != 2'd2);
    assign accept_s   = prod_valid && ce_out;
    assign prod_ext_s = $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    assign sum_s      = acc_q + prod_ext_s;

    // Accumulation, tap/row counting and result formation; clear wins over accept.
    always_comb begin
        acc_d       = acc_q;
        tap_d       = tap_q;
        row_d       = row_q;
        push_s      = 1'b0;
        push_data_s = {sat_round(sum_s), (row_q == ROW_LAST)};
        if (clear) begin
            acc_d = {ACC_W{1'b0}};
            tap_d = {TAP_W{1'b0}};
            row_d = {ROW_W{1'b0}};
        end else if (accept_s) begin
            if (tap_q == TAP_LAST) begin
                acc_d  = {ACC_W{1'b0}};
                tap_d  = {TAP_W{1'b0}};
                push_s = 1'b1;
                if (row_q == ROW_LAST) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                acc_d = sum_s;
                tap_d = tap_q + TAP_W'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
            tap_q <= {TAP_W{1'b0}};
            row_q <= {ROW_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            tap_q <= tap_d;
            row_q <= row_d;
        end
    end

    assign pop_s = out_valid && out_ready;

    dct_acc_out_fifo #(.W(OUT_W + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .count     (count_s),
        .head      (head_s)
    );

    assign out_valid = (count_s != 2'd0);
    assign out_data  = head_s[OUT_W:1];
    assign out_last  = head_s[0];

endmodule
